// File: rtl/pair_compute_engine_pkg.sv
// Shared encodings for the pair compute engine: op modes and controller states.
package pair_compute_engine_pkg;

  typedef enum logic [1:0] {
    PCE_CMPSEL = 2'b00,
    PCE_ABSDIF = 2'b01,
    PCE_SUM    = 2'b10,
    PCE_MAX    = 2'b11
  } pce_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } pce_state_e;

endpackage

// File: rtl/pair_compute_engine_alu.sv
// Combinational pair operator: result = f(a, b) truncated to W bits.
// carry is raised only by SUM when the true sum does not fit in W bits.
module pair_compute_engine_alu
  import pair_compute_engine_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  pce_mode_e    mode,
  output logic [W-1:0] result,
  output logic         carry
);

  logic [W:0] sum_full;

  always_comb begin
    sum_full = {1'b0, a} + {1'b0, b};
    result   = '0;
    carry    = 1'b0;
    unique case (mode)
      // legacy compare/select: equal operands take the add path
      PCE_CMPSEL: result = (a > b) ? (a - b) : sum_full[W-1:0];
      PCE_ABSDIF: result = (a >= b) ? (a - b) : (b - a);
      PCE_SUM: begin
        result = sum_full[W-1:0];
        carry  = sum_full[W];
      end
      PCE_MAX:    result = (a >= b) ? a : b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/pair_compute_engine.sv
// Buffers DEPTH source words, then walks adjacent pairs through the pair operator
// and writes DEPTH/2 results into a result RAM with a registered read port.
module pair_compute_engine
  import pair_compute_engine_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int RAW   = AW - 1
) (
  input  logic           clock,
  input  logic           Reset,
  input  logic           load_valid,
  input  logic [W-1:0]   load_data,
  output logic           load_ready,
  input  logic           start,
  input  logic [1:0]     mode,
  output logic           busy,
  output logic           done,
  output logic           ovf,
  input  logic [RAW-1:0] rd_addr,
  output logic [W-1:0]   rd_data
);

  pce_state_e     state_reg, state_next;
  logic [AW-1:0]  wr_ptr_reg;
  logic           full_reg;
  logic [RAW-1:0] idx_reg;
  pce_mode_e      mode_reg;
  logic           ovf_reg;
  logic [W-1:0]   rd_data_reg;
  logic [W-1:0]   a_reg, b_reg;

  logic [W-1:0] mem_a [DEPTH];
  logic [W-1:0] mem_r [DEPTH/2];

  logic         load_fire;
  logic         start_ok;
  logic         last_pair;
  logic [W-1:0] alu_result;
  logic         alu_carry;

  assign load_ready = (state_reg == ST_IDLE) && !full_reg;
  assign load_fire  = load_valid && load_ready;
  assign start_ok   = (state_reg == ST_IDLE) && full_reg && start;
  assign last_pair  = (idx_reg == RAW'(DEPTH/2 - 1));

  assign busy    = (state_reg == ST_RD0) || (state_reg == ST_RD1) || (state_reg == ST_WR);
  assign done    = (state_reg == ST_DONE);
  assign ovf     = ovf_reg;
  assign rd_data = rd_data_reg;

  pair_compute_engine_alu #(.W(W)) u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .mode   (mode_reg),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: if (start_ok) state_next = ST_RD0;
      ST_RD0:  state_next = ST_RD1;
      ST_RD1:  state_next = ST_WR;
      ST_WR:   state_next = last_pair ? ST_DONE : ST_RD0;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_reg   <= ST_IDLE;
      wr_ptr_reg  <= '0;
      full_reg    <= 1'b0;
      idx_reg     <= '0;
      mode_reg    <= PCE_CMPSEL;
      ovf_reg     <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rd_data_reg <= mem_r[rd_addr];
      // DEPTH is a power of two, so the pointer wraps to 0 on the last beat
      if (load_fire) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (wr_ptr_reg == AW'(DEPTH - 1)) full_reg <= 1'b1;
      end
      if (start_ok) begin
        mode_reg <= pce_mode_e'(mode);
        ovf_reg  <= 1'b0;
        idx_reg  <= '0;
      end
      if (state_reg == ST_WR) begin
        if (!last_pair) idx_reg <= idx_reg + RAW'(1);
        if (alu_carry) ovf_reg <= 1'b1;
      end
      if (state_reg == ST_DONE) full_reg <= 1'b0;
    end
  end

  // RAM ports and operand registers carry no reset so the arrays map onto block RAM
  always_ff @(posedge clock) begin
    if (load_fire) mem_a[wr_ptr_reg] <= load_data;
    if (state_reg == ST_RD0) a_reg <= mem_a[{idx_reg, 1'b0}];
    if (state_reg == ST_RD1) b_reg <= mem_a[{idx_reg, 1'b1}];
    if (state_reg == ST_WR) mem_r[idx_reg] <= alu_result;
  end

endmodule
